// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Brief    : Processor controller. Fetches 16-bit instructions from a
//             synchronous instruction ROM, decodes them and sequences the
//             Datapath through its control inputs. Holds PC and IR.
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int         PC_W    = 7,
    parameter logic [2:0] ALU_ADD = 3'b001,
    parameter logic [2:0] ALU_SUB = 3'b010
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [15:0]     I_data,
    output logic [PC_W-1:0] PC_addr,
    output logic [15:0]     IR_out,
    output logic [3:0]      State_out,
    output logic            Halted,
    output logic [7:0]      D_Addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      Alu_s0
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0]      c_op_store = 4'b0001;
    localparam logic [3:0]      c_op_load  = 4'b0010;
    localparam logic [3:0]      c_op_add   = 4'b0011;
    localparam logic [3:0]      c_op_sub   = 4'b0100;
    localparam logic [3:0]      c_op_halt  = 4'b0101;
    localparam logic [PC_W-1:0] c_pc_one   = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;

    // State register; en=0 freezes the sequencer in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else if (en) begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; unlisted opcodes fall through to the NOOP path.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:   w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (r_ir[15:12])
                    c_op_store: w_next_state = S_STORE;
                    c_op_load:  w_next_state = S_LOAD_A;
                    c_op_add:   w_next_state = S_ADD;
                    c_op_sub:   w_next_state = S_SUB;
                    c_op_halt:  w_next_state = S_HALT;
                    default:    w_next_state = S_NOOP;
                endcase
            end
            S_LOAD_A: w_next_state = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB:    w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_INIT;
        endcase
    end

    // PC and IR: PC advances only at the end of FETCH, so the ROM has the
    // whole DECODE cycle to present the next word before the next FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_ir <= '0;
        end else if (en) begin
            if (r_state == S_INIT) begin
                r_pc <= '0;
            end else if (r_state == S_FETCH) begin
                r_ir <= I_data;
                r_pc <= r_pc + c_pc_one;
            end
        end
    end

    // Moore control decode from current state and IR; everything idles at 0.
    always_comb begin
        D_Addr     = 8'd0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        Alu_s0     = 3'd0;
        case (r_state)
            S_LOAD_A,
            S_LOAD_B: begin
                D_Addr    = r_ir[11:4];
                RF_s      = 1'b1;
                RF_W_addr = r_ir[3:0];
                // LOAD_A only covers the data-memory read latency
                RF_W_en   = (r_state == S_LOAD_B);
            end
            S_STORE: begin
                D_Addr     = r_ir[7:0];
                RF_Ra_addr = r_ir[11:8];
                D_wr       = 1'b1;
            end
            S_ADD,
            S_SUB: begin
                RF_Ra_addr = r_ir[11:8];
                RF_Rb_addr = r_ir[7:4];
                Alu_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
                RF_W_addr  = r_ir[3:0];
                RF_W_en    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign PC_addr   = r_pc;
    assign IR_out    = r_ir;
    assign State_out = r_state;
    assign Halted    = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_control_unit
//  Brief    : Self-checking bench for control_unit. A program-level model
//             expands each ROM instruction into its expected cycle sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] I_data;
    logic [6:0]  PC_addr;
    logic [15:0] IR_out;
    logic [3:0]  State_out;
    logic        Halted;
    logic [7:0]  D_Addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  Alu_s0;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .I_data     (I_data),
        .PC_addr    (PC_addr),
        .IR_out     (IR_out),
        .State_out  (State_out),
        .Halted     (Halted),
        .D_Addr     (D_Addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .Alu_s0     (Alu_s0)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM with one-cycle registered read
    logic [15:0] rom [128];
    always @(posedge clk) I_data <= rom[PC_addr];

    localparam int K_NONE = 0;
    localparam int K_LDA  = 1;
    localparam int K_LDB  = 2;
    localparam int K_ST   = 3;
    localparam int K_ADD  = 4;
    localparam int K_SUB  = 5;
    localparam int K_HLT  = 6;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [26:0] ctl;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [26:0] obs_ctl;
    assign obs_ctl = {D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                      RF_Ra_addr, RF_Rb_addr, Alu_s0, Halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Control bundle an instruction class produces in its execute cycles
    function automatic logic [26:0] mk_ctl(input int kind, input logic [15:0] ir);
        logic [7:0] da  = 8'd0;
        logic       dw  = 1'b0;
        logic       rs  = 1'b0;
        logic       we  = 1'b0;
        logic       h   = 1'b0;
        logic [3:0] wa  = 4'd0;
        logic [3:0] ra  = 4'd0;
        logic [3:0] rb  = 4'd0;
        logic [2:0] alu = 3'd0;
        case (kind)
            K_LDA, K_LDB: begin
                da = ir[11:4]; rs = 1'b1; wa = ir[3:0]; we = (kind == K_LDB);
            end
            K_ST: begin
                da = ir[7:0]; dw = 1'b1; ra = ir[11:8];
            end
            K_ADD, K_SUB: begin
                ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1'b1;
                alu = (kind == K_ADD) ? 3'b001 : 3'b010;
            end
            K_HLT: h = 1'b1;
            default: ;
        endcase
        return {da, dw, rs, wa, we, ra, rb, alu, h};
    endfunction

    function automatic exp_t rec(input int st, input int pc, input logic [15:0] ir, input int kind);
        exp_t r;
        r.st  = 4'(st);
        r.pc  = 7'(pc);
        r.ir  = ir;
        r.ctl = mk_ctl(kind, ir);
        return r;
    endfunction

    // Expand the ROM program into the per-cycle sequence seen with en held high
    task automatic build_trace(input int n);
        int          pc = 0;
        logic [15:0] ir = 16'd0;
        logic [3:0]  op;
        q.delete();
        q.push_back(rec(0, 0, ir, K_NONE));
        while (q.size() < n) begin
            q.push_back(rec(1, pc, ir, K_NONE));
            ir = rom[pc];
            pc = (pc + 1) % 128;
            q.push_back(rec(2, pc, ir, K_NONE));
            op = ir[15:12];
            case (op)
                4'd1: q.push_back(rec(6, pc, ir, K_ST));
                4'd2: begin
                    q.push_back(rec(4, pc, ir, K_LDA));
                    q.push_back(rec(5, pc, ir, K_LDB));
                end
                4'd3: q.push_back(rec(7, pc, ir, K_ADD));
                4'd4: q.push_back(rec(8, pc, ir, K_SUB));
                4'd5: while (q.size() < n) q.push_back(rec(9, pc, ir, K_HLT));
                default: q.push_back(rec(3, pc, ir, K_NONE));
            endcase
        end
    endtask

    task automatic compare_now(input exp_t e);
        check("state", 32'(State_out), 32'(e.st));
        check("pc",    32'(PC_addr),   32'(e.pc));
        check("ir",    32'(IR_out),    32'(e.ir));
        check("ctl",   32'(obs_ctl),   32'(e.ctl));
        check("excl",  32'(D_wr & RF_W_en), 32'd0);
    endtask

    // Reset, then step n cycles; en=0 cycles must repeat the current record
    task automatic run_trace(input int n, input int en_pct, input bit hold_decode);
        int idx       = 0;
        int hold      = 0;
        bit held_done = 1'b0;
        build_trace(n + 8);
        en    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc++;
            compare_now(q[idx]);
            if (hold_decode && !held_done && q[idx].st == 4'd2) begin
                if (hold < 5) begin
                    en = 1'b0;
                    hold++;
                end else begin
                    en = 1'b1;
                    held_done = 1'b1;
                end
            end else begin
                en = ($urandom_range(0, 99) < en_pct);
            end
            @(posedge clk);
            if (en) idx++;
            @(negedge clk);
        end
        en = 1'b1;
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
    endtask

    task automatic reset_mid_store();
        bit found = 1'b0;
        fill_rom(16'h0000);
        rom[0] = 16'h132A;
        en     = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (State_out == 4'd6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("store_reached", 32'(found), 32'd1);
        check("store_dwr",     32'(D_wr),  32'd1);
        check("store_addr",    32'(D_Addr), 32'h2A);
        #2 rst_n = 1'b0;
        #1;
        check("rst_dwr",   32'(D_wr),      32'd0);
        check("rst_wen",   32'(RF_W_en),   32'd0);
        check("rst_state", 32'(State_out), 32'd0);
        check("rst_pc",    32'(PC_addr),   32'd0);
        check("rst_ir",    32'(IR_out),    32'd0);
        run_trace(12, 100, 1'b0);
    endtask

    initial begin
        logic [3:0] op;
        rst_n = 1'b0;
        en    = 1'b0;
        fill_rom(16'h0000);

        // Reference program: LOAD, NOOP, ADD, STORE, HALT with a DECODE stall
        rom[0] = 16'h21B1;
        rom[2] = 16'h3123;
        rom[3] = 16'h132A;
        rom[4] = 16'h5000;
        run_trace(45, 100, 1'b1);
        check("halt_flag", 32'(Halted),    32'd1);
        check("halt_pc",   32'(PC_addr),   32'd5);
        check("halt_st",   32'(State_out), 32'd9);

        // SUB variant and an undefined opcode on the NOOP path
        rom[1] = 16'hF000;
        rom[2] = 16'h4123;
        run_trace(24, 100, 1'b0);

        reset_mid_store();

        // NOOP stream long enough for the fetch at 127 to wrap PC to 0
        fill_rom(16'h0000);
        rom[5] = 16'hF000;
        run_trace(400, 100, 1'b0);

        // Random programs with random en stalls; halts kept rare
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 128; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd5 && (it < 2 || $urandom_range(0, 19) != 0)) op = 4'd3;
                rom[i] = {op, 12'($urandom)};
            end
            run_trace(500, 80, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
